video_timing_480p: RTL and testbench

VIDEO_TIMING_480P -- requirements
Module: video_timing_480p

---
 rtl/video_timing_480p_if.sv | 25 ++
 rtl/video_timing_480p.sv | 152 +++++++++++++++
 tb/tb_video_timing_480p.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_timing_480p_if.sv
// Video timing output bundle: syncs, data enable, raster position and frame pulse.
// The FRAME_CNT member exists only when VT_FRAME_CNT_EN is defined.
interface video_timing_480p_if;
  logic        HSYNC_n;
  logic        VSYNC_n;
  logic        DE;
  logic [9:0]  X;
  logic [9:0]  Y;
  logic        FRAME_START;
`ifdef VT_FRAME_CNT_EN
  logic [15:0] FRAME_CNT;
`endif

`ifdef VT_FRAME_CNT_EN
  modport master (output HSYNC_n, output VSYNC_n, output DE, output X, output Y,
                  output FRAME_START, output FRAME_CNT);
  modport slave  (input HSYNC_n, input VSYNC_n, input DE, input X, input Y,
                  input FRAME_START, input FRAME_CNT);
`else
  modport master (output HSYNC_n, output VSYNC_n, output DE, output X, output Y,
                  output FRAME_START);
  modport slave  (input HSYNC_n, input VSYNC_n, input DE, input X, input Y,
                  input FRAME_START);
`endif
endinterface

// File: rtl/video_timing_480p.sv
// 640x480 raster timing generator gated by a synchronized PLL lock; outputs are registered one cycle after (h,v).
// Optional 16-bit frame counter is built only when VT_FRAME_CNT_EN is defined.
module video_timing_480p #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic                PCLK,
  input  logic                RESET_n,
  input  logic                PLOCK,
  video_timing_480p_if.master vid
);

  localparam int CNT_W = 10;
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] H_DE_END = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_DE_END = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef enum logic {WAIT_LOCK = 1'b0, RUN = 1'b1} state_t;

  function automatic logic in_window(input logic [CNT_W-1:0] val,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (val >= lo) && (val <= hi);
  endfunction

  // PLOCK comes from another clock domain; nothing else may look at it.
  logic lock_meta;
  logic lock_s;

  always_ff @(posedge PCLK or negedge RESET_n) begin
    if (!RESET_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= PLOCK;
      lock_s    <= lock_meta;
    end
  end

  // Stage p0: lock FSM and raster counters; every relock restarts at (0,0).
  state_t               state;
  logic [CNT_W-1:0]     h_p0;
  logic [CNT_W-1:0]     v_p0;

  always_ff @(posedge PCLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state <= WAIT_LOCK;
      h_p0  <= '0;
      v_p0  <= '0;
    end else begin
      case (state)
        WAIT_LOCK: begin
          h_p0 <= '0;
          v_p0 <= '0;
          if (lock_s) state <= RUN;
        end
        RUN: begin
          if (!lock_s) begin
            state <= WAIT_LOCK;
            h_p0  <= '0;
            v_p0  <= '0;
          end else if (h_p0 == H_LAST) begin
            h_p0 <= '0;
            v_p0 <= (v_p0 == V_LAST) ? '0 : v_p0 + 1'b1;
          end else begin
            h_p0 <= h_p0 + 1'b1;
          end
        end
        default: state <= WAIT_LOCK;
      endcase
    end
  end

  logic vld_p0;
  logic de_c;
  logic hsync_c;
  logic vsync_c;
  logic fs_c;

  assign vld_p0  = (state == RUN);
  assign de_c    = (h_p0 < H_DE_END) && (v_p0 < V_DE_END);
  assign hsync_c = in_window(h_p0, HS_FIRST, HS_LAST);
  assign vsync_c = in_window(v_p0, VS_FIRST, VS_LAST);
  assign fs_c    = (h_p0 == '0) && (v_p0 == '0);

  // Stage p1: registered, mutually aligned outputs; idle values whenever not running.
  logic                 hsync_n_p1;
  logic                 vsync_n_p1;
  logic                 de_p1;
  logic [CNT_W-1:0]     x_p1;
  logic [CNT_W-1:0]     y_p1;
  logic                 fs_p1;

  always_ff @(posedge PCLK or negedge RESET_n) begin
    if (!RESET_n) begin
      hsync_n_p1 <= 1'b1;
      vsync_n_p1 <= 1'b1;
      de_p1      <= 1'b0;
      x_p1       <= '0;
      y_p1       <= '0;
      fs_p1      <= 1'b0;
    end else if (vld_p0) begin
      hsync_n_p1 <= ~hsync_c;
      vsync_n_p1 <= ~vsync_c;
      de_p1      <= de_c;
      x_p1       <= h_p0;
      y_p1       <= v_p0;
      fs_p1      <= fs_c;
    end else begin
      hsync_n_p1 <= 1'b1;
      vsync_n_p1 <= 1'b1;
      de_p1      <= 1'b0;
      x_p1       <= '0;
      y_p1       <= '0;
      fs_p1      <= 1'b0;
    end
  end

  assign vid.HSYNC_n     = hsync_n_p1;
  assign vid.VSYNC_n     = vsync_n_p1;
  assign vid.DE          = de_p1;
  assign vid.X           = x_p1;
  assign vid.Y           = y_p1;
  assign vid.FRAME_START = fs_p1;

`ifdef VT_FRAME_CNT_EN
  // Counts on the same edge that raises FRAME_START; untouched by lock loss.
  logic [15:0] frame_cnt_p1;

  always_ff @(posedge PCLK or negedge RESET_n) begin
    if (!RESET_n) begin
      frame_cnt_p1 <= '0;
    end else if (vld_p0 && fs_c) begin
      frame_cnt_p1 <= frame_cnt_p1 + 16'd1;
    end
  end

  assign vid.FRAME_CNT = frame_cnt_p1;
`endif

endmodule

// File: tb/tb_video_timing_480p.sv
// Bench for video_timing_480p on a reduced raster (32x19) so whole frames fit in a short run.
// Reference model tracks a linear frame position and lock-sample history; define VT_FRAME_CNT_EN to also check FRAME_CNT.
module tb_video_timing_480p;

  localparam int HA = 16, HFP = 4, HS = 6, HBP = 6;
  localparam int VA = 12, VFP = 2, VS = 2, VBP = 3;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;

  logic PCLK    = 1'b0;
  logic RESET_n = 1'b0;
  logic PLOCK   = 1'b0;

  video_timing_480p_if vif ();

  video_timing_480p #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut (
    .PCLK   (PCLK),
    .RESET_n(RESET_n),
    .PLOCK  (PLOCK),
    .vid    (vif)
  );

  always #5 PCLK = ~PCLK;

  int checks = 0;
  int errors = 0;

  typedef struct { bit hs_n; bit vs_n; bit de; int x; int y; bit fs; } vout_t;
  typedef struct { bit plock; bit de; bit fs; int x; int y; bit hs_n; bit vs_n; } vec_t;

  // Model: lock samples of the last two edges, running flag, linear position in the frame.
  bit    d1, d2, run_m;
  int    pos_m;
  int    exp_cnt;
  vout_t exp_o;

  function automatic vout_t idle_out();
    vout_t o;
    o.hs_n = 1'b1; o.vs_n = 1'b1; o.de = 1'b0; o.x = 0; o.y = 0; o.fs = 1'b0;
    return o;
  endfunction

  function automatic vout_t decode(int p);
    vout_t o;
    int h;
    int v;
    h = p % HT;
    v = p / HT;
    o.x    = h;
    o.y    = v;
    o.de   = (h < HA) && (v < VA);
    o.hs_n = !((h >= HA + HFP) && (h < HA + HFP + HS));
    o.vs_n = !((v >= VA + VFP) && (v < VA + VFP + VS));
    o.fs   = (p == 0);
    return o;
  endfunction

  function automatic vec_t mk(bit pl, bit de, bit fs, int x, int y, bit hs_n, bit vs_n);
    vec_t r;
    r.plock = pl; r.de = de; r.fs = fs; r.x = x; r.y = y; r.hs_n = hs_n; r.vs_n = vs_n;
    return r;
  endfunction

  task automatic model_reset();
    d1 = 1'b0; d2 = 1'b0; run_m = 1'b0; pos_m = 0; exp_cnt = 0;
    exp_o = idle_out();
  endtask

  task automatic model_edge(input bit sample);
    bit run_new;
    run_new = d2;
    exp_o = run_m ? decode(pos_m) : idle_out();
    if (exp_o.fs) exp_cnt = (exp_cnt + 1) % 65536;
    pos_m = (run_m && run_new) ? (pos_m + 1) % FRAME : 0;
    run_m = run_new;
    d2 = d1;
    d1 = sample;
  endtask

  task automatic check_model();
    bit bad;
    checks++;
    bad = (vif.HSYNC_n !== exp_o.hs_n) || (vif.VSYNC_n !== exp_o.vs_n) ||
          (vif.DE !== exp_o.de) || (vif.X !== 10'(exp_o.x)) ||
          (vif.Y !== 10'(exp_o.y)) || (vif.FRAME_START !== exp_o.fs);
`ifdef VT_FRAME_CNT_EN
    if (vif.FRAME_CNT !== 16'(exp_cnt)) bad = 1'b1;
`endif
    if (bad) begin
      errors++;
      $display("FAIL model t=%0t: got hs_n=%b vs_n=%b de=%b x=%0d y=%0d fs=%b, expected hs_n=%b vs_n=%b de=%b x=%0d y=%0d fs=%b",
               $time, vif.HSYNC_n, vif.VSYNC_n, vif.DE, vif.X, vif.Y, vif.FRAME_START,
               exp_o.hs_n, exp_o.vs_n, exp_o.de, exp_o.x, exp_o.y, exp_o.fs);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    if (!RESET_n) model_reset();
    else model_edge(PLOCK);
    #1;
    check_model();
  endtask

  function automatic bit outputs_idle();
    return (vif.DE === 1'b0) && (vif.FRAME_START === 1'b0) && (vif.X === 10'd0) &&
           (vif.Y === 10'd0) && (vif.HSYNC_n === 1'b1) && (vif.VSYNC_n === 1'b1);
  endfunction

  vec_t tbl [8];
  int   n, n2, fs_seen;
  int   gap, de_cnt, de_runs, bad_runs, run_len, de_fall_x;
  int   hs_fall_x, hs_len, hs_first_len, hs_total;
  int   vs_cnt, vs_x, vs_y;
  bit   prev_de, prev_hs, prev_vs;

  initial begin
    model_reset();
    tbl[0] = mk(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
    tbl[1] = mk(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
    tbl[2] = mk(1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
    tbl[3] = mk(1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
    tbl[4] = mk(1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
    tbl[5] = mk(1'b1, 1'b1, 1'b1, 0, 0, 1'b1, 1'b1);
    tbl[6] = mk(1'b1, 1'b1, 1'b0, 1, 0, 1'b1, 1'b1);
    tbl[7] = mk(1'b1, 1'b1, 1'b0, 2, 0, 1'b1, 1'b1);

    // Reset state
    repeat (3) step();
    chk("reset_de", vif.DE, 0);
    chk("reset_hsync_n", vif.HSYNC_n, 1);
    chk("reset_vsync_n", vif.VSYNC_n, 1);
    chk("reset_xy", {vif.X, vif.Y}, 0);
    RESET_n = 1'b1;

    // Lock-up latency table: PLOCK first sampled high at table entry 2 (E0)
    for (int i = 0; i < 8; i++) begin
      PLOCK = tbl[i].plock;
      step();
      checks++;
      if (vif.DE !== tbl[i].de || vif.FRAME_START !== tbl[i].fs || vif.X !== 10'(tbl[i].x) ||
          vif.Y !== 10'(tbl[i].y) || vif.HSYNC_n !== tbl[i].hs_n || vif.VSYNC_n !== tbl[i].vs_n) begin
        errors++;
        $display("FAIL startup[%0d]: got de=%b fs=%b x=%0d y=%0d hs_n=%b vs_n=%b, expected de=%b fs=%b x=%0d y=%0d hs_n=%b vs_n=%b",
                 i, vif.DE, vif.FRAME_START, vif.X, vif.Y, vif.HSYNC_n, vif.VSYNC_n,
                 tbl[i].de, tbl[i].fs, tbl[i].x, tbl[i].y, tbl[i].hs_n, tbl[i].vs_n);
      end
    end

    // Full-frame measurements between two FRAME_START pulses
    n = 0;
    while (vif.FRAME_START !== 1'b1 && n < 2 * FRAME) begin step(); n++; end
    chk("frame_start_found", vif.FRAME_START, 1);
    gap = 0; de_cnt = 0; de_runs = 0; bad_runs = 0; run_len = 0; de_fall_x = -1;
    hs_fall_x = -1; hs_len = 0; hs_first_len = -1; hs_total = 0;
    vs_cnt = 0; vs_x = -1; vs_y = -1;
    prev_de = 1'b0; prev_hs = 1'b1; prev_vs = 1'b1;
    do begin
      if (vif.DE === 1'b1) begin de_cnt++; run_len++; end
      if (vif.DE !== 1'b1 && prev_de) begin
        de_runs++;
        if (run_len != HA) bad_runs++;
        if (de_fall_x < 0) de_fall_x = int'(vif.X);
        run_len = 0;
      end
      if (vif.HSYNC_n === 1'b0) begin
        hs_total++; hs_len++;
        if (prev_hs && hs_fall_x < 0) hs_fall_x = int'(vif.X);
      end
      if (vif.HSYNC_n === 1'b1 && !prev_hs) begin
        if (hs_first_len < 0) hs_first_len = hs_len;
        hs_len = 0;
      end
      if (vif.VSYNC_n === 1'b0) begin
        vs_cnt++;
        if (prev_vs) begin vs_x = int'(vif.X); vs_y = int'(vif.Y); end
      end
      prev_de = vif.DE; prev_hs = vif.HSYNC_n; prev_vs = vif.VSYNC_n;
      step();
      gap++;
    end while (vif.FRAME_START !== 1'b1 && gap < 2 * FRAME);
    chk("frame_period", gap, FRAME);
    chk("de_high_cycles", de_cnt, HA * VA);
    chk("de_runs", de_runs, VA);
    chk("de_runs_wrong_length", bad_runs, 0);
    chk("de_fall_x", de_fall_x, HA);
    chk("hsync_start_x", hs_fall_x, HA + HFP);
    chk("hsync_width", hs_first_len, HS);
    chk("hsync_low_total", hs_total, HS * VT);
    chk("vsync_low_cycles", vs_cnt, HT * VS);
    chk("vsync_start_x", vs_x, 0);
    chk("vsync_start_y", vs_y, VA + VFP);

    // Lock loss mid-frame, then relock restarts at (0,0)
    n = 0;
    while (!(vif.X === 10'd10 && vif.Y === 10'd5) && n < 2 * FRAME) begin step(); n++; end
    chk("reached_drop_point", {vif.X, vif.Y}, {10'd10, 10'd5});
    PLOCK = 1'b0;
    n = 0;
    do begin step(); n++; end while (!outputs_idle() && n < 20);
    chk("drop_to_idle_edges", n, 4);
    repeat (10) step();
    chk("idle_while_unlocked", outputs_idle(), 1);
    PLOCK = 1'b1;
    n = 0;
    do begin step(); n++; end while (vif.FRAME_START !== 1'b1 && n < 20);
    chk("relock_fs_edges", n, 4);
    chk("relock_xy", {vif.X, vif.Y}, 0);
    chk("relock_de", vif.DE, 1);

    // Asynchronous reset mid-line, then three frames from a clean start
    repeat (50) step();
    #2;
    RESET_n = 1'b0;
    #1;
    model_reset();
    check_model();
    chk("async_reset_idle", outputs_idle(), 1);
    step();
    RESET_n = 1'b1;
    n = 0;
    do begin step(); n++; end while (vif.FRAME_START !== 1'b1 && n < 20);
    chk("post_reset_fs_edges", n, 4);
    n2 = 0; fs_seen = 1;
    while (fs_seen < 3 && n2 < 3 * FRAME) begin
      step(); n2++;
      if (vif.FRAME_START === 1'b1) fs_seen++;
    end
    chk("three_frames_cycles", n2, 2 * FRAME);
`ifdef VT_FRAME_CNT_EN
    chk("frame_cnt_after_3", vif.FRAME_CNT, 3);
`endif
    PLOCK = 1'b0;
    repeat (12) step();
    chk("idle_after_second_drop", outputs_idle(), 1);
`ifdef VT_FRAME_CNT_EN
    chk("frame_cnt_held_unlocked", vif.FRAME_CNT, 3);
`endif

    // Random lock toggling, including short glitches, against the model
    for (int seg = 0; seg < 14; seg++) begin
      int hold;
      PLOCK = ~PLOCK;
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(20, 900));
      repeat (hold) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
